dma_timing_ctrl: RTL and testbench

DMA_TIMING_CTRL -- requirements
Module: dma_timing_ctrl

---
 rtl/dma_pkg.sv | 43 ++++
 rtl/dma_cmd_strobe.sv | 48 ++++
 rtl/dma_timing_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dma_timing_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types for the DMA timing controller: one-hot state encoding,
// channel mode and transfer-type codes, and the command strobe bundle.
package dma_pkg;

   typedef enum logic [6:0] {
      ST_SI = 7'b000_0001,
      ST_S0 = 7'b000_0010,
      ST_S1 = 7'b000_0100,
      ST_S2 = 7'b000_1000,
      ST_S3 = 7'b001_0000,
      ST_SW = 7'b010_0000,
      ST_S4 = 7'b100_0000
   } state_e;

   typedef enum logic [1:0] {
      MODE_DEMAND = 2'b00,
      MODE_SINGLE = 2'b01,
      MODE_BLOCK  = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      XFER_VERIFY  = 2'b00,
      XFER_WRITE   = 2'b01,
      XFER_READ    = 2'b10,
      XFER_ILLEGAL = 2'b11
   } xfer_e;

   typedef struct packed {
      logic memr_n;
      logic memw_n;
      logic ior_n;
      logic iow_n;
   } strobe_t;

   localparam strobe_t STROBE_IDLE = 4'b1111;

   // True in the states where the bus belongs to the DMA (AEN/DACK active).
   function automatic logic is_bus_phase(state_e s);
      return s inside {ST_S1, ST_S2, ST_S3, ST_SW, ST_S4};
   endfunction

endpackage

// File: rtl/dma_cmd_strobe.sv
// Command strobe generator. Decodes the upcoming state and the latched
// transfer type into registered active-low strobes, so the strobes line up
// with the state register. Macro DMA_EXT_WRITE_EN: write strobe starts in S2
// together with the read strobe (extended write); default starts it in S3.
module dma_cmd_strobe
   import dma_pkg::*;
(
   input  logic    clk,
   input  logic    reset_n,
   input  state_e  state_nxt,
   input  xfer_e   xfer,
   output strobe_t strobe
);

   logic rd_phase;
   logic wr_phase;

   // Phase windows of the read-side and write-side strobes.
   always_comb begin
      rd_phase = state_nxt inside {ST_S2, ST_S3, ST_SW, ST_S4};
`ifdef DMA_EXT_WRITE_EN
      wr_phase = rd_phase;
`else
      wr_phase = state_nxt inside {ST_S3, ST_SW, ST_S4};
`endif
   end

   // Register the strobes; verify and illegal types never drive the bus.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         strobe <= STROBE_IDLE;
      end else begin
         strobe <= STROBE_IDLE;
         case (xfer)
            XFER_WRITE: begin
               strobe.ior_n  <= !rd_phase;
               strobe.memw_n <= !wr_phase;
            end
            XFER_READ: begin
               strobe.memr_n <= !rd_phase;
               strobe.iow_n  <= !wr_phase;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/dma_timing_ctrl.sv
// DMA timing controller: sequences one channel's bus cycles from grant to
// end of transfer. Outputs are registered from the next state so they are
// aligned with the state register; EOP_OUT_N is the only decoded output
// because TC_IN is only known during S4. Macro DMA_EXT_WRITE_EN selects the
// extended-write strobe timing in dma_cmd_strobe.
//
// state | meaning
// SI    | idle, waiting for a grant; latches channel, mode and type
// S0    | hold request, waiting for HLDA
// S1    | upper address strobe (first word or upper byte change)
// S2    | read strobe asserted
// S3    | write strobe asserted, READY sampled
// SW    | wait states until READY, optional abort after SW_LIMIT cycles
// S4    | word done, end-of-transfer decision
module dma_timing_ctrl
   import dma_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int SW_LIMIT = 0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     gnt_valid,
   input  logic [$clog2(NCH)-1:0]   gnt_ch,
   input  logic [2*NCH-1:0]         ch_mode,
   input  logic [2*NCH-1:0]         ch_xfer,
   input  logic [NCH-1:0]           req_live,
   input  logic                     hlda,
   input  logic                     ready,
   input  logic                     tc_in,
   input  logic                     upper_chg,
   input  logic                     eop_in_n,
   output logic                     hrq,
   output logic                     aen,
   output logic                     adstb,
   output logic                     memr_n,
   output logic                     memw_n,
   output logic                     ior_n,
   output logic                     iow_n,
   output logic [NCH-1:0]           dack_onehot,
   output logic                     word_done,
   output logic [NCH-1:0]           tc_stat,
   output logic                     eop_out_n,
   output logic                     abort
);

   localparam int CW  = $clog2(NCH);
   localparam int SWW = (SW_LIMIT > 1) ? $clog2(SW_LIMIT + 1) : 1;

   state_e         state;
   state_e         state_nxt;
   logic [CW-1:0]  ch;
   mode_e          mode;
   xfer_e          xfer;
   logic           eop_seen;
   logic           hlda_lost;
   logic [SWW-1:0] sw_left;
   logic           sw_expire;
   logic           xfer_end;
   logic           next_word;
   strobe_t        strobe;

   // Next-state decode. sw_left counts down the remaining allowed SW cycles;
   // reaching 1 with READY still low means the limit is used up.
   always_comb begin
      sw_expire = (SW_LIMIT > 0) && (state == ST_SW) && !ready && (sw_left == SWW'(1));
      xfer_end  = tc_in || eop_seen || !eop_in_n;
      case (mode)
         MODE_BLOCK:  next_word = 1'b1;
         MODE_DEMAND: next_word = req_live[ch];
         default:     next_word = 1'b0;
      endcase
      if (xfer_end || hlda_lost || !hlda)
         next_word = 1'b0;

      state_nxt = state;
      case (state)
         ST_SI: if (gnt_valid) state_nxt = ST_S0;
         ST_S0: if (hlda) state_nxt = ST_S1;
         ST_S1: state_nxt = ST_S2;
         ST_S2: state_nxt = ST_S3;
         ST_S3: state_nxt = ready ? ST_S4 : ST_SW;
         ST_SW: begin
            if (sw_expire)
               state_nxt = ST_SI;
            else if (ready)
               state_nxt = ST_S4;
         end
         ST_S4: begin
            if (!next_word)
               state_nxt = ST_SI;
            else
               state_nxt = upper_chg ? ST_S1 : ST_S2;
         end
         default: state_nxt = ST_SI;
      endcase
   end

   // State register, per-transfer context and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_SI;
         ch          <= '0;
         mode        <= MODE_DEMAND;
         xfer        <= XFER_VERIFY;
         eop_seen    <= 1'b0;
         hlda_lost   <= 1'b0;
         sw_left     <= '0;
         hrq         <= 1'b0;
         aen         <= 1'b0;
         adstb       <= 1'b0;
         dack_onehot <= '0;
         word_done   <= 1'b0;
         tc_stat     <= '0;
         abort       <= 1'b0;
      end else begin
         state       <= state_nxt;
         hrq         <= (state_nxt != ST_SI);
         aen         <= is_bus_phase(state_nxt);
         adstb       <= (state_nxt == ST_S1);
         word_done   <= (state_nxt == ST_S4);
         abort       <= sw_expire;
         dack_onehot <= '0;
         if (is_bus_phase(state_nxt))
            dack_onehot[ch] <= 1'b1;

         if (state == ST_SI && gnt_valid) begin
            ch   <= gnt_ch;
            mode <= mode_e'(ch_mode[{gnt_ch, 1'b0} +: 2]);
            xfer <= xfer_e'(ch_xfer[{gnt_ch, 1'b0} +: 2]);
         end

         // End requests seen mid-word are held until the S4 decision.
         if (state == ST_S0) begin
            eop_seen  <= 1'b0;
            hlda_lost <= 1'b0;
         end else begin
            if ((state inside {ST_S2, ST_S3, ST_SW, ST_S4}) && !eop_in_n)
               eop_seen <= 1'b1;
            if (is_bus_phase(state) && !hlda)
               hlda_lost <= 1'b1;
         end

         if (state == ST_S3)
            sw_left <= SWW'(SW_LIMIT);
         else if (state == ST_SW)
            sw_left <= sw_left - SWW'(1);

         if (state == ST_S4 && tc_in)
            tc_stat[ch] <= 1'b1;
      end
   end

   assign eop_out_n = !(state == ST_S4 && tc_in);

   dma_cmd_strobe u_cmd_strobe (
      .clk       (clk),
      .reset_n   (reset_n),
      .state_nxt (state_nxt),
      .xfer      (xfer),
      .strobe    (strobe)
   );

   assign memr_n = strobe.memr_n;
   assign memw_n = strobe.memw_n;
   assign ior_n  = strobe.ior_n;
   assign iow_n  = strobe.iow_n;

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Directed bench for dma_timing_ctrl. Two instances share the stimulus:
// dut (unlimited wait states) and dut_lim (SW_LIMIT = 2).
// Output bundle per cycle: {hrq, aen, adstb, memr_n, memw_n, ior_n, iow_n, word_done}.
module tb_dma_timing_ctrl;

`ifdef DMA_EXT_WRITE_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   localparam logic [7:0] B_SI  = 8'b00011110;
   localparam logic [7:0] B_S0  = 8'b10011110;
   localparam logic [7:0] B_S1  = 8'b11111110;
   localparam logic [7:0] B_RD2 = EXT ? 8'b11001100 : 8'b11001110;
   localparam logic [7:0] B_RD3 = 8'b11001100;
   localparam logic [7:0] B_RD4 = 8'b11001101;
   localparam logic [7:0] B_WR2 = EXT ? 8'b11010010 : 8'b11011010;
   localparam logic [7:0] B_WR3 = 8'b11010010;
   localparam logic [7:0] B_WR4 = 8'b11010011;
   localparam logic [7:0] B_VF2 = 8'b11011110;
   localparam logic [7:0] B_VF3 = 8'b11011110;
   localparam logic [7:0] B_VF4 = 8'b11011111;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       gnt_valid;
   logic [1:0] gnt_ch;
   logic [7:0] ch_mode;
   logic [7:0] ch_xfer;
   logic [3:0] req_live;
   logic       hlda, ready, tc_in, upper_chg, eop_in_n;

   logic       hrq, aen, adstb, memr_n, memw_n, ior_n, iow_n, word_done, eop_out_n, abort;
   logic [3:0] dack_onehot, tc_stat;
   logic       l_hrq, l_aen, l_adstb, l_memr_n, l_memw_n, l_ior_n, l_iow_n, l_word_done, l_eop_out_n, l_abort;
   logic [3:0] l_dack_onehot, l_tc_stat;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dma_timing_ctrl #(.NCH(4), .SW_LIMIT(0)) dut (
      .clk(clk), .reset_n(reset_n), .gnt_valid(gnt_valid), .gnt_ch(gnt_ch),
      .ch_mode(ch_mode), .ch_xfer(ch_xfer), .req_live(req_live), .hlda(hlda),
      .ready(ready), .tc_in(tc_in), .upper_chg(upper_chg), .eop_in_n(eop_in_n),
      .hrq(hrq), .aen(aen), .adstb(adstb), .memr_n(memr_n), .memw_n(memw_n),
      .ior_n(ior_n), .iow_n(iow_n), .dack_onehot(dack_onehot), .word_done(word_done),
      .tc_stat(tc_stat), .eop_out_n(eop_out_n), .abort(abort)
   );

   dma_timing_ctrl #(.NCH(4), .SW_LIMIT(2)) dut_lim (
      .clk(clk), .reset_n(reset_n), .gnt_valid(gnt_valid), .gnt_ch(gnt_ch),
      .ch_mode(ch_mode), .ch_xfer(ch_xfer), .req_live(req_live), .hlda(hlda),
      .ready(ready), .tc_in(tc_in), .upper_chg(upper_chg), .eop_in_n(eop_in_n),
      .hrq(l_hrq), .aen(l_aen), .adstb(l_adstb), .memr_n(l_memr_n), .memw_n(l_memw_n),
      .ior_n(l_ior_n), .iow_n(l_iow_n), .dack_onehot(l_dack_onehot), .word_done(l_word_done),
      .tc_stat(l_tc_stat), .eop_out_n(l_eop_out_n), .abort(l_abort)
   );

   function automatic logic [7:0] obs_main();
      return {hrq, aen, adstb, memr_n, memw_n, ior_n, iow_n, word_done};
   endfunction

   function automatic logic [7:0] obs_lim();
      return {l_hrq, l_aen, l_adstb, l_memr_n, l_memw_n, l_ior_n, l_iow_n, l_word_done};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      gnt_valid = 1'b0;
      gnt_ch    = 2'd0;
      req_live  = 4'b0000;
      hlda      = 1'b0;
      ready     = 1'b1;
      tc_in     = 1'b0;
      upper_chg = 1'b0;
      eop_in_n  = 1'b1;
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; gnt_valid = 1'b1; gnt_ch = 2'd2; ch_mode = 8'hAA; ch_xfer = 8'hAA;
      req_live = 4'hF; hlda = 1'b1; ready = 1'b0; tc_in = 1'b1; upper_chg = 1'b1; eop_in_n = 1'b0;
      step();
      step();
      n_cmp++; if (obs_main() !== B_SI) begin n_fail++; $display("FAIL reset_outputs got %b want %b", obs_main(), B_SI); end
      n_cmp++; if ({dack_onehot, tc_stat} !== 8'h00) begin n_fail++; $display("FAIL reset_dack_tc got %b want %b", {dack_onehot, tc_stat}, 8'h00); end
      n_cmp++; if ({abort, eop_out_n} !== 2'b01) begin n_fail++; $display("FAIL reset_abort_eop got %b want 01", {abort, eop_out_n}); end
      n_cmp++; if (obs_lim() !== B_SI) begin n_fail++; $display("FAIL reset_lim_outputs got %b want %b", obs_lim(), B_SI); end
   endtask

   // Block read ch2; grant changes after SI must be ignored.
   task automatic test_block_read();
      logic [7:0] exp [10];
      exp = '{B_S0, B_S0, B_S1, B_RD2, B_RD3, B_RD4, B_RD2, B_RD3, B_RD4, B_SI};
      ch_mode = 8'b01_10_01_01; ch_xfer = 8'b01_10_01_01;
      gnt_valid = 1'b1; gnt_ch = 2'd2; hlda = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         gnt_ch = 2'd1; gnt_valid = (i < 8); hlda = (i >= 1); tc_in = (i == 8);
         #1;
         n_cmp++; if (obs_main() !== exp[i]) begin n_fail++; $display("FAIL block_read cyc%0d got %b want %b", i, obs_main(), exp[i]); end
         n_cmp++; if (dack_onehot !== ((i >= 2 && i <= 8) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL block_read_dack cyc%0d got %b", i, dack_onehot); end
         n_cmp++; if (eop_out_n !== (i != 8)) begin n_fail++; $display("FAIL block_read_eop cyc%0d got %b want %b", i, eop_out_n, (i != 8)); end
      end
      tc_in = 1'b0;
      step();
      n_cmp++; if (tc_stat !== 4'b0100) begin n_fail++; $display("FAIL block_read_tc got %b want 0100", tc_stat); end
   endtask

   // Single write ch0: back to SI after each word, HRQ low between words.
   task automatic test_single_write();
      logic [7:0] exp [12];
      exp = '{B_S0, B_S1, B_WR2, B_WR3, B_WR4, B_SI, B_S0, B_S1, B_WR2, B_WR3, B_WR4, B_SI};
      ch_mode = 8'b10_10_10_01; ch_xfer = 8'b10_10_10_01;
      gnt_valid = 1'b1; gnt_ch = 2'd0; hlda = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         gnt_valid = (i == 5);
         #1;
         n_cmp++; if (obs_main() !== exp[i]) begin n_fail++; $display("FAIL single_write cyc%0d got %b want %b", i, obs_main(), exp[i]); end
         n_cmp++; if (dack_onehot !== ((i inside {[1:4], [7:10]}) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL single_write_dack cyc%0d got %b", i, dack_onehot); end
      end
      n_cmp++; if (tc_stat !== 4'b0000) begin n_fail++; $display("FAIL single_write_tc got %b want 0000", tc_stat); end
   endtask

   // Block read ch1 with READY low for 3 cycles; dut_lim aborts instead.
   task automatic test_wait_states();
      logic [7:0] exp [9];
      logic [7:0] lexp [9];
      int wd_cnt = 0;
      int lwd_cnt = 0;
      exp  = '{B_S0, B_S1, B_RD2, B_RD3, B_RD3, B_RD3, B_RD3, B_RD4, B_SI};
      lexp = '{B_S0, B_S1, B_RD2, B_RD3, B_RD3, B_RD3, B_SI, B_SI, B_SI};
      ch_mode = 8'b01_01_10_01; ch_xfer = 8'b01_01_10_01;
      gnt_valid = 1'b1; gnt_ch = 2'd1; hlda = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         gnt_valid = 1'b0; ready = !(i >= 3 && i <= 5); tc_in = (i == 7);
         #1;
         if (word_done) wd_cnt++;
         if (l_word_done) lwd_cnt++;
         n_cmp++; if (obs_main() !== exp[i]) begin n_fail++; $display("FAIL wait cyc%0d got %b want %b", i, obs_main(), exp[i]); end
         n_cmp++; if (obs_lim() !== lexp[i]) begin n_fail++; $display("FAIL wait_lim cyc%0d got %b want %b", i, obs_lim(), lexp[i]); end
         n_cmp++; if ({abort, l_abort} !== {1'b0, (i == 6)}) begin n_fail++; $display("FAIL wait_abort cyc%0d got %b want %b", i, {abort, l_abort}, {1'b0, (i == 6)}); end
      end
      tc_in = 1'b0;
      n_cmp++; if (wd_cnt !== 1) begin n_fail++; $display("FAIL wait_word_done got %0d want 1", wd_cnt); end
      n_cmp++; if (lwd_cnt !== 0) begin n_fail++; $display("FAIL wait_lim_word_done got %0d want 0", lwd_cnt); end
   endtask

   // Demand verify ch3, upper byte change after word 1, request falls in word 2.
   task automatic test_demand();
      logic [7:0] exp [10];
      exp = '{B_S0, B_S1, B_VF2, B_VF3, B_VF4, B_S1, B_VF2, B_VF3, B_VF4, B_SI};
      ch_mode = 8'b00_10_10_10; ch_xfer = 8'b00_01_01_01;
      gnt_valid = 1'b1; gnt_ch = 2'd3; hlda = 1'b1; req_live = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         step();
         gnt_valid = 1'b0; upper_chg = (i == 4); req_live = (i < 5) ? 4'b1111 : 4'b0111;
         #1;
         n_cmp++; if (obs_main() !== exp[i]) begin n_fail++; $display("FAIL demand cyc%0d got %b want %b", i, obs_main(), exp[i]); end
         n_cmp++; if (dack_onehot !== ((i >= 1 && i <= 8) ? 4'b1000 : 4'b0000)) begin n_fail++; $display("FAIL demand_dack cyc%0d got %b", i, dack_onehot); end
      end
      upper_chg = 1'b0;
      n_cmp++; if (tc_stat !== 4'b0000) begin n_fail++; $display("FAIL demand_tc got %b want 0000", tc_stat); end
   endtask

   // Block read ch1, TC and external EOP in the same S4.
   task automatic test_tc_eop();
      logic [7:0] exp [10];
      int eop_cnt = 0;
      exp = '{B_S0, B_S1, B_RD2, B_RD3, B_RD4, B_RD2, B_RD3, B_RD4, B_SI, B_SI};
      ch_mode = 8'b01_01_10_01; ch_xfer = 8'b01_01_10_01;
      gnt_valid = 1'b1; gnt_ch = 2'd1; hlda = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         gnt_valid = 1'b0; tc_in = (i == 7); eop_in_n = (i != 7);
         #1;
         if (!eop_out_n) eop_cnt++;
         n_cmp++; if (obs_main() !== exp[i]) begin n_fail++; $display("FAIL tc_eop cyc%0d got %b want %b", i, obs_main(), exp[i]); end
      end
      tc_in = 1'b0; eop_in_n = 1'b1;
      n_cmp++; if (eop_cnt !== 1) begin n_fail++; $display("FAIL tc_eop_pulses got %0d want 1", eop_cnt); end
      n_cmp++; if (tc_stat !== 4'b0010) begin n_fail++; $display("FAIL tc_eop_stat got %b want 0010", tc_stat); end
   endtask

   // Block read ch2 ended early by EOP in S2 (use_hlda=0) or HLDA loss (use_hlda=1).
   task automatic test_early_end(input bit use_hlda);
      logic [7:0] exp [7];
      exp = '{B_S0, B_S1, B_RD2, B_RD3, B_RD4, B_SI, B_SI};
      ch_mode = 8'b10_10_10_10; ch_xfer = 8'b10_10_10_10;
      gnt_valid = 1'b1; gnt_ch = 2'd2; hlda = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         gnt_valid = 1'b0;
         hlda = use_hlda ? (i < 2) : 1'b1;
         eop_in_n = use_hlda ? 1'b1 : (i != 2);
         #1;
         n_cmp++; if (obs_main() !== exp[i]) begin n_fail++; $display("FAIL early_end%0d cyc%0d got %b want %b", use_hlda, i, obs_main(), exp[i]); end
         n_cmp++; if (eop_out_n !== 1'b1) begin n_fail++; $display("FAIL early_end%0d_eop cyc%0d got %b want 1", use_hlda, i, eop_out_n); end
      end
      eop_in_n = 1'b1;
      n_cmp++; if (tc_stat !== 4'b0000) begin n_fail++; $display("FAIL early_end%0d_tc got %b want 0000", use_hlda, tc_stat); end
   endtask

   // Reset asserted while both instances sit in SW.
   task automatic test_reset_during_sw();
      logic [7:0] exp [6];
      exp = '{B_S0, B_S1, B_RD2, B_RD3, B_RD3, B_RD3};
      ch_mode = 8'b01_10_01_01; ch_xfer = 8'b01_10_01_01;
      gnt_valid = 1'b1; gnt_ch = 2'd2; hlda = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         gnt_valid = 1'b0; ready = !(i >= 3); reset_n = (i != 5);
         #1;
         n_cmp++; if (obs_main() !== exp[i] || obs_lim() !== exp[i]) begin n_fail++; $display("FAIL sw_reset cyc%0d got %b/%b want %b", i, obs_main(), obs_lim(), exp[i]); end
      end
      step();
      reset_n = 1'b1; ready = 1'b1;
      #1;
      n_cmp++; if (obs_main() !== B_SI) begin n_fail++; $display("FAIL sw_reset_main got %b want %b", obs_main(), B_SI); end
      n_cmp++; if (obs_lim() !== B_SI) begin n_fail++; $display("FAIL sw_reset_lim got %b want %b", obs_lim(), B_SI); end
      n_cmp++; if ({dack_onehot, l_dack_onehot, tc_stat, l_tc_stat} !== 16'h0000) begin n_fail++; $display("FAIL sw_reset_vec got %h want 0000", {dack_onehot, l_dack_onehot, tc_stat, l_tc_stat}); end
      n_cmp++; if ({abort, l_abort, eop_out_n, l_eop_out_n} !== 4'b0011) begin n_fail++; $display("FAIL sw_reset_flags got %b want 0011", {abort, l_abort, eop_out_n, l_eop_out_n}); end
   endtask

   initial begin
      test_reset();
      do_reset(); test_block_read();
      do_reset(); test_single_write();
      do_reset(); test_wait_states();
      do_reset(); test_demand();
      do_reset(); test_tc_eop();
      do_reset(); test_early_end(1'b0);
      do_reset(); test_early_end(1'b1);
      do_reset(); test_reset_during_sw();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout sim time exceeded");
      $fatal(1);
   end

endmodule
